floor_request_queue: RTL and testbench

Collects hall/car call button presses, debounces them, keeps a pending-request bitmap and drives the target floor into `elevator_state_machine` using a SCAN (elevator) policy. It sits directly upstream of the car controller: its `requested_floor` feeds that FSM's `requested_floor`, and it consumes `current_floor` and the idle indication the FSM produces. A request is retired when the car is idle at that floor.

---
 rtl/floor_request_queue_if.sv | 36 +++
 rtl/floor_request_queue.sv | 161 ++++++++++++++++
 tb/tb_floor_request_queue.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/floor_request_queue_if.sv
// Call-button and scheduler bundle between the hall/car panel, the car FSM
// and the floor request queue.
interface floor_request_queue_if #(
    parameter int NUM_FLOORS = 10
);
    logic                  call_press;
    logic [3:0]            call_floor;
    logic [3:0]            current_floor;
    logic                  car_idle;
    logic [3:0]            requested_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  req_valid;
    logic                  call_reject;

    modport master (
        output call_press,
        output call_floor,
        output current_floor,
        output car_idle,
        input  requested_floor,
        input  pending,
        input  req_valid,
        input  call_reject
    );

    modport slave (
        input  call_press,
        input  call_floor,
        input  current_floor,
        input  car_idle,
        output requested_floor,
        output pending,
        output req_valid,
        output call_reject
    );
endinterface

// File: rtl/floor_request_queue.sv
// Debounced call capture, pending-request bitmap and SCAN target selection
// feeding the elevator car FSM.
module floor_request_queue #(
    parameter int NUM_FLOORS      = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input logic                  clk,
    input logic                  rst,
    floor_request_queue_if.slave bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SERVE_UP,
        SERVE_DOWN
    } sched_e;

    logic [1:0]            press_sync_q;
    logic [3:0]            floor_s1_q;
    logic [3:0]            floor_s2_q;
    logic                  deb_q;
    logic                  deb_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  acc_q;
    logic                  acc_d;
    logic [3:0]            acc_floor_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] pending_d;
    logic                  req_valid_q;
    logic                  reject_q;
    logic                  reject_d;
    sched_e                state_q;
    sched_e                state_d;
    logic [3:0]            target_q;
    logic [3:0]            target_d;
    logic                  up_any;
    logic                  dn_any;
    logic [3:0]            up_tgt;
    logic [3:0]            dn_tgt;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (press_sync_q[1] != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = press_sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign acc_d = deb_d & ~deb_q;

    // Clear wins over set so a request at the idle car's floor is dropped.
    always_comb begin
        pending_d = pending_q;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (acc_q && acc_floor_q == 4'(f)) begin
                pending_d[f] = 1'b1;
            end
            if (bus.car_idle && bus.current_floor == 4'(f)) begin
                pending_d[f] = 1'b0;
            end
        end
        reject_d = acc_q && ({1'b0, acc_floor_q} >= 5'(NUM_FLOORS));
    end

    always_comb begin
        up_any = 1'b0;
        dn_any = 1'b0;
        up_tgt = bus.current_floor;
        dn_tgt = bus.current_floor;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (pending_q[f] && 4'(f) > bus.current_floor) begin
                up_any = 1'b1;
                up_tgt = 4'(f);
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending_q[f] && 4'(f) < bus.current_floor) begin
                dn_any = 1'b1;
                dn_tgt = 4'(f);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = bus.current_floor;
        unique case (state_q)
            SCHED_IDLE: begin
                if (up_any) begin
                    state_d  = SERVE_UP;
                    target_d = up_tgt;
                end else if (dn_any) begin
                    state_d  = SERVE_DOWN;
                    target_d = dn_tgt;
                end
            end
            SERVE_UP: begin
                if (up_any) begin
                    target_d = up_tgt;
                end else if (dn_any) begin
                    state_d = SERVE_DOWN;
                end else begin
                    state_d = SCHED_IDLE;
                end
            end
            SERVE_DOWN: begin
                if (dn_any) begin
                    target_d = dn_tgt;
                end else if (up_any) begin
                    state_d = SERVE_UP;
                end else begin
                    state_d = SCHED_IDLE;
                end
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_sync_q <= '0;
            floor_s1_q   <= '0;
            floor_s2_q   <= '0;
            deb_q        <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            acc_floor_q  <= '0;
            pending_q    <= '0;
            req_valid_q  <= 1'b0;
            reject_q     <= 1'b0;
            state_q      <= SCHED_IDLE;
            target_q     <= '0;
        end else begin
            press_sync_q <= {press_sync_q[0], bus.call_press};
            floor_s1_q   <= bus.call_floor;
            floor_s2_q   <= floor_s1_q;
            deb_q        <= deb_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            if (acc_d) begin
                acc_floor_q <= floor_s2_q;
            end
            pending_q    <= pending_d;
            req_valid_q  <= |pending_d;
            reject_q     <= reject_d;
            state_q      <= state_d;
            target_q     <= target_d;
        end
    end

    assign bus.requested_floor = target_q;
    assign bus.pending         = pending_q;
    assign bus.req_valid       = req_valid_q;
    assign bus.call_reject     = reject_q;
endmodule

// File: tb/tb_floor_request_queue.sv
// Directed bench for floor_request_queue with a short debounce window.
module tb_floor_request_queue;
    localparam int NF = 10;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   rej_cnt = 0;

    floor_request_queue_if #(.NUM_FLOORS(NF)) bus ();

    floor_request_queue #(
        .NUM_FLOORS     (NF),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.call_reject === 1'b1) rej_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] f);
        bus.call_press = 1'b1;
        bus.call_floor = f;
        tick(7);
        bus.call_press = 1'b0;
        tick(7);
    endtask

    initial begin
        bus.call_press    = 1'b0;
        bus.call_floor    = 4'd0;
        bus.current_floor = 4'd0;
        bus.car_idle      = 1'b1;
        rst = 1'b1;
        tick(2);
        chk("rst_req", 32'(bus.requested_floor), 0);
        chk("rst_pend", 32'(bus.pending), 0);
        chk("rst_valid", 32'(bus.req_valid), 0);
        chk("rst_rej", 32'(bus.call_reject), 0);
        rst = 1'b0;
        tick(1);

        // clean press of floor 3, car idle at 0
        bus.call_press = 1'b1;
        bus.call_floor = 4'd3;
        tick(6);
        chk("p3_early", 32'(bus.pending), 0);
        tick(1);
        chk("p3_pend", 32'(bus.pending), 32'h008);
        chk("p3_valid", 32'(bus.req_valid), 1);
        chk("p3_req_pre", 32'(bus.requested_floor), 0);
        tick(1);
        chk("p3_req", 32'(bus.requested_floor), 3);
        bus.call_press = 1'b0;
        tick(7);
        chk("p3_once", 32'(bus.pending), 32'h008);

        // car arrives idle at 3
        bus.current_floor = 4'd3;
        tick(2);
        chk("clr3_pend", 32'(bus.pending), 0);
        chk("clr3_valid", 32'(bus.req_valid), 0);
        chk("clr3_req", 32'(bus.requested_floor), 3);

        // short glitch
        bus.call_press = 1'b1;
        bus.call_floor = 4'd4;
        tick(3);
        bus.call_press = 1'b0;
        tick(10);
        chk("glitch_pend", 32'(bus.pending), 0);
        chk("glitch_rej", 32'(rej_cnt), 0);

        // car moving up from 2, request 7 then 5
        bus.car_idle      = 1'b0;
        bus.current_floor = 4'd2;
        press(4'd7);
        chk("up7_req", 32'(bus.requested_floor), 7);
        press(4'd5);
        chk("up5_pend", 32'(bus.pending), 32'h0A0);
        chk("up5_req", 32'(bus.requested_floor), 5);
        bus.current_floor = 4'd5;
        bus.car_idle      = 1'b1;
        tick(2);
        chk("at5_pend", 32'(bus.pending), 32'h080);
        chk("at5_req", 32'(bus.requested_floor), 7);

        // clear 7, then pending {1,6} with car at 4 heading up
        bus.current_floor = 4'd7;
        tick(2);
        chk("at7_pend", 32'(bus.pending), 0);
        bus.car_idle      = 1'b0;
        bus.current_floor = 4'd4;
        press(4'd6);
        press(4'd1);
        chk("scan_pend", 32'(bus.pending), 32'h042);
        chk("scan_req6", 32'(bus.requested_floor), 6);
        bus.current_floor = 4'd6;
        bus.car_idle      = 1'b1;
        tick(1);
        chk("scan_sw_req", 32'(bus.requested_floor), 6);
        tick(1);
        chk("scan_req1", 32'(bus.requested_floor), 1);
        chk("scan_pend1", 32'(bus.pending), 32'h002);
        bus.car_idle      = 1'b0;
        bus.current_floor = 4'd3;
        tick(2);
        chk("scan_mid_req", 32'(bus.requested_floor), 1);
        bus.current_floor = 4'd1;
        bus.car_idle      = 1'b1;
        tick(2);
        chk("scan_end_pend", 32'(bus.pending), 0);
        chk("scan_end_valid", 32'(bus.req_valid), 0);
        chk("scan_end_req", 32'(bus.requested_floor), 1);

        // out-of-range floor code
        bus.call_press = 1'b1;
        bus.call_floor = 4'd12;
        tick(7);
        chk("rej_pulse", 32'(bus.call_reject), 1);
        chk("rej_pend", 32'(bus.pending), 0);
        tick(1);
        chk("rej_drop", 32'(bus.call_reject), 0);
        bus.call_press = 1'b0;
        tick(7);
        chk("rej_count", 32'(rej_cnt), 1);

        // pending {2,8}, reset mid-travel with floor 8 held
        bus.car_idle      = 1'b0;
        bus.current_floor = 4'd5;
        press(4'd2);
        chk("dn2_req", 32'(bus.requested_floor), 2);
        press(4'd8);
        chk("two_pend", 32'(bus.pending), 32'h104);
        bus.call_press = 1'b1;
        bus.call_floor = 4'd8;
        tick(3);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus.requested_floor), 0);
        chk("mid_rst_pend", 32'(bus.pending), 0);
        chk("mid_rst_valid", 32'(bus.req_valid), 0);
        chk("mid_rst_rej", 32'(bus.call_reject), 0);
        tick(2);
        rst = 1'b0;
        tick(6);
        chk("held_early", 32'(bus.pending), 0);
        tick(1);
        chk("held_pend", 32'(bus.pending), 32'h100);
        tick(10);
        chk("held_once", 32'(bus.pending), 32'h100);
        chk("held_req", 32'(bus.requested_floor), 8);
        bus.call_press = 1'b0;
        tick(7);

        // car position beyond the last floor
        bus.current_floor = 4'd12;
        tick(1);
        chk("hi_sw_req", 32'(bus.requested_floor), 12);
        tick(1);
        chk("hi_req", 32'(bus.requested_floor), 8);
        chk("final_rej", 32'(rej_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
